spike_rate_encoder: RTL and testbench

Upstream stage of the neuromorphic input layer. Converts one frame of NUM_CH unsigned 8-bit intensities into WINDOW consecutive NUM_CH-bit spike vectors using rate coding.
- Each output vector is one timestep, consumed directly as the input layer's spike vector plus spike-valid.
- Adds valid/ready handshaking on both sides and keeps frame and spike statistics.

---
 rtl/spike_rate_encoder_pkg.sv | 22 ++
 rtl/spike_rate_encoder_if.sv | 27 ++
 rtl/spike_rate_channel.sv | 56 +++++
 rtl/spike_rate_encoder.sv | 136 +++++++++++++
 tb/tb_spike_rate_encoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_rate_encoder_pkg.sv
// Shared constants and types for the neuromorphic input-layer encoder.
package neuro_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int WINDOW_DEF = 16;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } enc_state_e;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: taps on bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Frame-in / spike-out handshake bundle; master is the environment, slave the encoder.
interface spike_rate_encoder_if
  import neuro_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH-1:0]        spike_out;
  logic                     spike_valid;
  logic                     spike_ready;
  logic                     frame_last;

  modport master (
    output in_data, in_valid, spike_ready,
    input  in_ready, spike_out, spike_valid, frame_last
  );

  modport slave (
    input  in_data, in_valid, spike_ready,
    output in_ready, spike_out, spike_valid, frame_last
  );

endinterface

// File: rtl/spike_rate_channel.sv
// One spike lane: rate accumulator, or LFSR threshold comparator when SPIKE_ENC_LFSR_EN is defined.
// Spike bit registered on step_i and held otherwise, so the top's hold-under-stall comes for free.
module spike_rate_channel
  import neuro_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              step_i,
  input  logic              clr_i,
`ifdef SPIKE_ENC_LFSR_EN
  input  logic [DATA_W-1:0] rnd_i,
`endif
  output logic              spike_o
);

  logic spike_d;
  logic spike_q;

`ifdef SPIKE_ENC_LFSR_EN
  logic unused_clr;

  assign unused_clr = clr_i;
  assign spike_d    = (data_i > rnd_i);
`else
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W:0]   acc_d;

  // Carry-out of the running sum is the spike; the residue stays in acc.
  assign acc_d   = {1'b0, acc_q} + {1'b0, data_i};
  assign spike_d = acc_d[DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d[DATA_W-1:0];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= 1'b0;
    end else if (step_i) begin
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes one frame of NUM_CH intensities into WINDOW spike vectors; SPIKE_ENC_LFSR_EN selects stochastic coding.
// First step registered the cycle after accept, then 1 step/cycle; outputs hold while spike_ready is low.
module spike_rate_encoder
  import neuro_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  spike_rate_encoder_if.slave   bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      frames_encoded,
  output logic [CNT_W-1:0]      spikes_emitted
);

  localparam int STEP_W = $clog2(WINDOW + 1);

  enc_state_e               state_q;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [STEP_W-1:0]        step_cnt_q;
  logic                     spike_valid_q;
  logic                     frame_last_q;
  logic                     busy_q;
  logic [CNT_W-1:0]         frames_q;
  logic [CNT_W-1:0]         spikes_q;
  logic [NUM_CH-1:0]        spike_vec;

  logic accept;
  logic step;
  logic out_hs;
  logic last_hs;

  assign bus.in_ready = enable && (state_q == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = spike_valid_q && bus.spike_ready;
  assign last_hs      = out_hs && frame_last_q;

  // Once all WINDOW steps exist, wait for the last handshake instead of generating more.
  assign step = enable && (state_q == ENCODE) &&
                (step_cnt_q != STEP_W'(WINDOW)) &&
                (!spike_valid_q || bus.spike_ready);

`ifdef SPIKE_ENC_LFSR_EN
  logic [15:0] lfsr_q;
  logic [31:0] lfsr_dbl;

  assign lfsr_dbl = {lfsr_q, lfsr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef SPIKE_ENC_LFSR_EN
    // Low DATA_W bits of the LFSR rotated left by 2*i.
    localparam int SH = (2 * i) % 16;
`endif
    spike_rate_channel #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_q[i*DATA_W +: DATA_W]),
      .step_i  (step),
      .clr_i   (accept),
`ifdef SPIKE_ENC_LFSR_EN
      .rnd_i   (lfsr_dbl[16-SH +: DATA_W]),
`endif
      .spike_o (spike_vec[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      step_cnt_q    <= '0;
      spike_valid_q <= 1'b0;
      frame_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      frames_q      <= '0;
      spikes_q      <= '0;
    end else begin
      if (out_hs) begin
        spikes_q <= spikes_q + CNT_W'($countones(spike_vec));
      end
      if (last_hs) begin
        frames_q <= frames_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q     <= bus.in_data;
            step_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ENCODE;
          end
        end
        ENCODE: begin
          if (last_hs) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (step) begin
        spike_valid_q <= 1'b1;
        frame_last_q  <= (step_cnt_q == STEP_W'(WINDOW - 1));
        step_cnt_q    <= step_cnt_q + STEP_W'(1);
      end else if (out_hs) begin
        spike_valid_q <= 1'b0;
        frame_last_q  <= 1'b0;
      end
    end
  end

  assign bus.spike_out   = spike_vec;
  assign bus.spike_valid = spike_valid_q;
  assign bus.frame_last  = frame_last_q;
  assign busy            = busy_q;
  assign frames_encoded  = frames_q;
  assign spikes_emitted  = spikes_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: random frames and backpressure against a closed-form rate-coding model.
module tb_spike_rate_encoder;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int WINDOW = 16;
  localparam int CNT_W  = 32;
  localparam int DW     = NUM_CH * DATA_W;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             busy;
  logic [CNT_W-1:0] frames_encoded;
  logic [CNT_W-1:0] spikes_emitted;

  spike_rate_encoder_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  spike_rate_encoder #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .bus            (bus),
    .busy           (busy),
    .frames_encoded (frames_encoded),
    .spikes_emitted (spikes_emitted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [CNT_W-1:0]  exp_frames;
  logic [CNT_W-1:0]  exp_spikes;
  logic [NUM_CH-1:0] obs_vec  [WINDOW];
  logic              obs_last [WINDOW];
  int obs_n, hold_err, rdy_err, pause_hs, acc_cyc, fv_cyc, last_cyc;

  // Step k (1-based) spikes on channel i when floor(d*k/2^W) advances.
  function automatic logic [NUM_CH-1:0] model_vec(input logic [DW-1:0] d, input int k);
    logic [NUM_CH-1:0] v;
    int di;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      di   = int'(d[i*DATA_W +: DATA_W]);
      v[i] = ((di * k) / (1 << DATA_W)) != ((di * (k - 1)) / (1 << DATA_W));
    end
    return v;
  endfunction

  function automatic int model_pop(input logic [DW-1:0] d, input int n);
    int s;
    s = 0;
    for (int k = 1; k <= n; k++) s += $countones(model_vec(d, k));
    return s;
  endfunction

  function automatic logic [DW-1:0] rand_frame();
    logic [DW-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(255));
    return d;
  endfunction

  // Offers frame d, then collects stop_after handshakes; cycle 0 is the first negedge after the call.
  task automatic run_frame(input logic [DW-1:0] d, input int rdy_pct, input int stop_after,
                           input int pause_at, input bit hold_next, input logic [DW-1:0] d_next);
    int cyc, pause_left;
    bit acc_done, pend, paused_done;
    logic [NUM_CH-1:0] h_vec;
    logic h_last;
    obs_n = 0; hold_err = 0; rdy_err = 0; pause_hs = 0;
    acc_cyc = -1; fv_cyc = -1; last_cyc = -1;
    acc_done = 0; pend = 0; paused_done = 0; pause_left = 0; cyc = 0;
    h_vec = '0; h_last = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (obs_n < stop_after && cyc < 400) begin
      @(negedge clk);
      if (acc_done) begin
        bus.in_valid = hold_next;
        if (hold_next) bus.in_data = d_next;
      end
      if (pause_at >= 0 && !paused_done && obs_n == pause_at && bus.spike_valid) begin
        pause_left  = 5;
        paused_done = 1;
      end
      enable          = (pause_left == 0);
      bus.spike_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (!acc_done) begin
        if (bus.in_ready) begin
          acc_done = 1;
          acc_cyc  = cyc;
        end
      end else if (bus.in_ready) begin
        rdy_err++;
      end
      if (bus.spike_valid) begin
        if (fv_cyc < 0) fv_cyc = cyc;
        if (pend && (bus.spike_out !== h_vec || bus.frame_last !== h_last)) hold_err++;
        if (bus.spike_ready) begin
          obs_vec[obs_n]  = bus.spike_out;
          obs_last[obs_n] = bus.frame_last;
          obs_n++;
          pend     = 0;
          last_cyc = cyc;
          if (pause_left > 0) pause_hs++;
        end else begin
          pend   = 1;
          h_vec  = bus.spike_out;
          h_last = bus.frame_last;
        end
      end else if (pend) begin
        hold_err++;
      end
      if (pause_left > 0) pause_left--;
      cyc++;
    end
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.spike_ready = 1'b0;
    #1;
    cmp_cnt++;
    if (bus.in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL reset_in_ready_dis: got %b want 0", bus.in_ready);
    end
    enable = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL reset_in_ready_en: got %b want 1", bus.in_ready);
    end
    cmp_cnt++;
    if ({bus.spike_valid, bus.frame_last, busy, bus.spike_out, frames_encoded, spikes_emitted} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: valid=%b last=%b busy=%b spikes=%b frames=%0d emitted=%0d want all 0",
               bus.spike_valid, bus.frame_last, busy, bus.spike_out, frames_encoded, spikes_emitted);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_frames = '0;
    exp_spikes = '0;
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d;
    d = rand_frame();
    run_frame(d, 100, 6, -1, 1'b0, '0);
    cmp_cnt++;
    if (obs_n !== 6) begin
      err_cnt++; $display("FAIL midrst_steps: got %0d want 6", obs_n);
    end
    for (int k = 0; k < obs_n; k++) begin
      cmp_cnt++;
      if (obs_vec[k] !== model_vec(d, k + 1)) begin
        err_cnt++; $display("FAIL midrst_vec step %0d: got %b want %b", k + 1, obs_vec[k], model_vec(d, k + 1));
      end
    end
    @(negedge clk);
    cmp_cnt++;
    if ({busy, bus.spike_valid} !== 2'b11) begin
      err_cnt++; $display("FAIL midrst_step7_pending: busy/valid got %b%b want 11", busy, bus.spike_valid);
    end
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if ({bus.spike_valid, bus.frame_last, busy, bus.spike_out, frames_encoded, spikes_emitted} !== '0
        || bus.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_outputs: valid=%b last=%b busy=%b spikes=%b frames=%0d emitted=%0d rdy=%b want 0s, rdy=1",
               bus.spike_valid, bus.frame_last, busy, bus.spike_out, frames_encoded, spikes_emitted, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_frames = '0;
    exp_spikes = '0;
    d = rand_frame();
    run_frame(d, 100, WINDOW, -1, 1'b0, '0);
    for (int k = 0; k < WINDOW; k++) begin
      cmp_cnt++;
      if (k >= obs_n || obs_vec[k] !== model_vec(d, k + 1) || obs_last[k] !== (k == WINDOW - 1)) begin
        err_cnt++; $display("FAIL midrst_next_frame step %0d: got %b want %b (seen %0d)", k + 1, obs_vec[k], model_vec(d, k + 1), obs_n);
      end
    end
    exp_frames += 1;
    exp_spikes += CNT_W'(model_pop(d, WINDOW));
    @(posedge clk); #1;
    cmp_cnt++;
    if (frames_encoded !== exp_frames || spikes_emitted !== exp_spikes) begin
      err_cnt++; $display("FAIL midrst_counters: frames %0d emitted %0d want %0d %0d", frames_encoded, spikes_emitted, exp_frames, exp_spikes);
    end
  endtask

  task automatic test_uniform();
    logic [DW-1:0] d;
    int total;
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = 8'd128;
    run_frame(d, 100, WINDOW, -1, 1'b0, '0);
    total = 0;
    for (int k = 0; k < WINDOW; k++) begin
      cmp_cnt++;
      if (k >= obs_n || obs_vec[k] !== model_vec(d, k + 1) || obs_last[k] !== (k == WINDOW - 1)) begin
        err_cnt++; $display("FAIL uniform step %0d: got %b last=%b want %b", k + 1, obs_vec[k], obs_last[k], model_vec(d, k + 1));
      end
      if (k < obs_n) total += $countones(obs_vec[k]);
    end
    cmp_cnt++;
    if (total !== 64) begin
      err_cnt++; $display("FAIL uniform_total: got %0d want 64", total);
    end
    cmp_cnt++;
    if (!((fv_cyc - acc_cyc) inside {[1:2]}) || (last_cyc - fv_cyc) !== WINDOW - 1) begin
      err_cnt++; $display("FAIL uniform_timing: accept %0d first %0d last %0d want first within 2, %0d consecutive", acc_cyc, fv_cyc, last_cyc, WINDOW);
    end
    exp_frames += 1;
    exp_spikes += CNT_W'(model_pop(d, WINDOW));
    @(posedge clk); #1;
    cmp_cnt++;
    if (frames_encoded !== exp_frames || spikes_emitted !== exp_spikes || busy !== 1'b0) begin
      err_cnt++; $display("FAIL uniform_counters: frames %0d emitted %0d busy %b want %0d %0d 0", frames_encoded, spikes_emitted, busy, exp_frames, exp_spikes);
    end
  endtask

  task automatic test_mixed();
    logic [DW-1:0] d;
    int vals [NUM_CH] = '{0, 255, 64, 32, 16, 1, 200, 100};
    int want [NUM_CH] = '{0, 15, 4, 2, 1, 0, 12, 6};
    int cnt;
    for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = DATA_W'(vals[i]);
    run_frame(d, 100, WINDOW, -1, 1'b0, '0);
    for (int i = 0; i < NUM_CH; i++) begin
      cnt = 0;
      for (int k = 0; k < obs_n; k++) cnt += int'(obs_vec[k][i]);
      cmp_cnt++;
      if (cnt !== want[i]) begin
        err_cnt++; $display("FAIL mixed_count ch%0d: got %0d want %0d", i, cnt, want[i]);
      end
    end
    for (int k = 0; k < obs_n; k++) begin
      cmp_cnt++;
      if (obs_vec[k] !== model_vec(d, k + 1)) begin
        err_cnt++; $display("FAIL mixed_vec step %0d: got %b want %b", k + 1, obs_vec[k], model_vec(d, k + 1));
      end
    end
    exp_frames += 1;
    exp_spikes += CNT_W'(model_pop(d, WINDOW));
    @(posedge clk); #1;
    cmp_cnt++;
    if (frames_encoded !== exp_frames || spikes_emitted !== exp_spikes) begin
      err_cnt++; $display("FAIL mixed_counters: frames %0d emitted %0d want %0d %0d", frames_encoded, spikes_emitted, exp_frames, exp_spikes);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) for (int i = 0; i < NUM_CH; i++) d[i*DATA_W +: DATA_W] = 8'd128;
      else d = rand_frame();
      run_frame(d, 30 + 20 * f, WINDOW, -1, 1'b0, '0);
      cmp_cnt++;
      if (obs_n !== WINDOW || hold_err !== 0) begin
        err_cnt++; $display("FAIL bp_hold frame %0d: steps %0d hold_err %0d want %0d 0", f, obs_n, hold_err, WINDOW);
      end
      for (int k = 0; k < obs_n; k++) begin
        cmp_cnt++;
        if (obs_vec[k] !== model_vec(d, k + 1) || obs_last[k] !== (k == WINDOW - 1)) begin
          err_cnt++; $display("FAIL bp_vec frame %0d step %0d: got %b last=%b want %b", f, k + 1, obs_vec[k], obs_last[k], model_vec(d, k + 1));
        end
      end
      exp_frames += 1;
      exp_spikes += CNT_W'(model_pop(d, WINDOW));
      @(posedge clk); #1;
      cmp_cnt++;
      if (frames_encoded !== exp_frames || spikes_emitted !== exp_spikes) begin
        err_cnt++; $display("FAIL bp_counters frame %0d: frames %0d emitted %0d want %0d %0d", f, frames_encoded, spikes_emitted, exp_frames, exp_spikes);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] da, db;
    da = rand_frame();
    db = rand_frame();
    run_frame(da, 100, WINDOW, -1, 1'b1, db);
    cmp_cnt++;
    if (rdy_err !== 0 || obs_n !== WINDOW) begin
      err_cnt++; $display("FAIL b2b_in_ready_busy: cycles with in_ready=1 %0d steps %0d want 0 %0d", rdy_err, obs_n, WINDOW);
    end
    exp_frames += 1;
    exp_spikes += CNT_W'(model_pop(da, WINDOW));
    @(posedge clk); #1;
    cmp_cnt++;
    if (frames_encoded !== exp_frames) begin
      err_cnt++; $display("FAIL b2b_frames_a: got %0d want %0d", frames_encoded, exp_frames);
    end
    run_frame(db, 100, WINDOW, -1, 1'b0, '0);
    cmp_cnt++;
    if (acc_cyc !== 0) begin
      err_cnt++; $display("FAIL b2b_accept_gap: accept %0d cycles after bubble start want 0", acc_cyc);
    end
    for (int k = 0; k < obs_n; k++) begin
      cmp_cnt++;
      if (obs_vec[k] !== model_vec(db, k + 1)) begin
        err_cnt++; $display("FAIL b2b_vec step %0d: got %b want %b", k + 1, obs_vec[k], model_vec(db, k + 1));
      end
    end
    exp_frames += 1;
    exp_spikes += CNT_W'(model_pop(db, WINDOW));
    @(posedge clk); #1;
    cmp_cnt++;
    if (frames_encoded !== exp_frames || spikes_emitted !== exp_spikes) begin
      err_cnt++; $display("FAIL b2b_counters: frames %0d emitted %0d want %0d %0d", frames_encoded, spikes_emitted, exp_frames, exp_spikes);
    end
  endtask

  task automatic test_pause();
    logic [DW-1:0] d;
    d = rand_frame();
    run_frame(d, 100, WINDOW, 3, 1'b0, '0);
    cmp_cnt++;
    if (pause_hs !== 1) begin
      err_cnt++; $display("FAIL pause_steps: handshakes while paused %0d want 1", pause_hs);
    end
    for (int k = 0; k < WINDOW; k++) begin
      cmp_cnt++;
      if (k >= obs_n || obs_vec[k] !== model_vec(d, k + 1) || obs_last[k] !== (k == WINDOW - 1)) begin
        err_cnt++; $display("FAIL pause_vec step %0d: got %b want %b (seen %0d)", k + 1, obs_vec[k], model_vec(d, k + 1), obs_n);
      end
    end
    exp_frames += 1;
    exp_spikes += CNT_W'(model_pop(d, WINDOW));
    @(posedge clk); #1;
    cmp_cnt++;
    if (frames_encoded !== exp_frames || spikes_emitted !== exp_spikes) begin
      err_cnt++; $display("FAIL pause_counters: frames %0d emitted %0d want %0d %0d", frames_encoded, spikes_emitted, exp_frames, exp_spikes);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_uniform();
    test_mixed();
    test_backpressure();
    test_back_to_back();
    test_pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
